// File: rtl/t03_branch_resolve_predict.sv
// t03_branch_resolve_predict
//
// Branch unit that resolves branch outcomes from the ALU flags and predicts
// branch direction with a PC-indexed table of saturating counters. Fetch reads
// a prediction combinationally. Execute resolves the branch, updates the
// table, and raises a registered one-cycle mispredict pulse. Saturating
// statistics count resolved branches and mispredicts.
//
// Parameters
//   ENTRIES  number of predictor entries (power of 2, >= 2)
//   CTR_W    saturating counter width (>= 1); the prediction is the counter MSB
//   PC_W     program counter width
//   STAT_W   statistics counter width
//
// Ports
//   clk, rst                   clock and synchronous active-high reset
//   en                         pipeline enable; low stalls all state
//   fetch_pc / pred_taken      fetch-side prediction lookup
//   resolve_valid, resolve_pc,
//   resolve_pred, branch_type  execute-side resolution request
//   ALU_*_flag                 ALU condition flags used to resolve
//   b_out, mispredict          registered outcome and mispredict pulse
//   branch_cnt, mispredict_cnt saturating statistics
module t03_branch_resolve_predict #(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int PC_W    = 32,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [PC_W-1:0]   fetch_pc,
    output logic              pred_taken,
    input  logic              resolve_valid,
    input  logic [PC_W-1:0]   resolve_pc,
    input  logic              resolve_pred,
    input  logic [2:0]        branch_type,
    input  logic              ALU_neg_flag,
    input  logic              ALU_zero_flag,
    input  logic              ALU_overflow_flag,
    output logic              b_out,
    output logic              mispredict,
    output logic [STAT_W-1:0] branch_cnt,
    output logic [STAT_W-1:0] mispredict_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);

    // Reset value is "weakly not-taken": MSB clear, every lower bit set.
    localparam logic [CTR_W-1:0]  CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0]  CTR_MAX  = '1;
    localparam logic [CTR_W-1:0]  CTR_ONE  = CTR_W'(1);
    localparam logic [STAT_W-1:0] STAT_MAX = '1;
    localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

    logic [CTR_W-1:0] ctr_table [ENTRIES];

    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] resolve_idx;
    logic [CTR_W-1:0] resolve_ctr;
    logic             taken;
    logic             fire;
    logic             is_cond;
    logic             is_branch;
    logic             mp_cond;

    // The PC bits outside the index field are intentionally ignored, so PCs
    // that share an index alias onto the same counter.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[PC_W-1:IDX_W+2], fetch_pc[1:0],
                              resolve_pc[PC_W-1:IDX_W+2], resolve_pc[1:0]};

    // Instructions are word aligned, so the index skips the low two PC bits.
    assign fetch_idx   = fetch_pc[IDX_W+1:2];
    assign resolve_idx = resolve_pc[IDX_W+1:2];
    assign resolve_ctr = ctr_table[resolve_idx];
    assign pred_taken  = ctr_table[fetch_idx][CTR_W-1];

    assign fire      = en & resolve_valid;
    assign is_branch = (branch_type != 3'd0);
    assign is_cond   = is_branch && (branch_type != 3'd7);
    assign mp_cond   = (taken != resolve_pred);

    // Conditional types are suppressed by signed overflow. JUMP is always
    // taken and ignores overflow. LTU/GEU share the neg flag, which the ALU
    // sets from the unsigned compare for those operations.
    always_comb begin
        taken = 1'b0;
        case (branch_type)
            3'd1:    taken = !ALU_overflow_flag &&  ALU_zero_flag;
            3'd2:    taken = !ALU_overflow_flag && !ALU_zero_flag;
            3'd3:    taken = !ALU_overflow_flag &&  ALU_neg_flag;
            3'd4:    taken = !ALU_overflow_flag && !ALU_neg_flag;
            3'd5:    taken = !ALU_overflow_flag &&  ALU_neg_flag;
            3'd6:    taken = !ALU_overflow_flag && !ALU_neg_flag;
            3'd7:    taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    // Resolution, table training and statistics. While en is low, everything
    // holds, including the outcome and mispredict registers. A type-0
    // instruction that fetch predicted taken still reports a mispredict so
    // that the wrong path gets flushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_table[i] <= CTR_INIT;
            end
            b_out          <= 1'b0;
            mispredict     <= 1'b0;
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (en) begin
            b_out      <= resolve_valid & taken;
            mispredict <= resolve_valid & mp_cond;

            if (fire && is_cond) begin
                if (taken) begin
                    if (resolve_ctr != CTR_MAX) begin
                        ctr_table[resolve_idx] <= resolve_ctr + CTR_ONE;
                    end
                end else begin
                    if (resolve_ctr != '0) begin
                        ctr_table[resolve_idx] <= resolve_ctr - CTR_ONE;
                    end
                end
            end

            if (fire && is_branch && (branch_cnt != STAT_MAX)) begin
                branch_cnt <= branch_cnt + STAT_ONE;
            end

            if (fire && mp_cond && (mispredict_cnt != STAT_MAX)) begin
                mispredict_cnt <= mispredict_cnt + STAT_ONE;
            end
        end
    end

endmodule
